up_down_counter_ctrl: RTL and testbench

//  Sequencer for a chain of NUM_DIGITS BCD up/down digit counters (digit 0 = LSD).
//  - Divides clk into a count tick and drives per-digit enable with BCD carry/borrow ripple.
//  - Holds the shared count direction and generates the digit-counter clear (active-high).
//  - Run/pause/clear command FSM; optional terminal-count stop (timer mode).

---
 rtl/up_down_counter_ctrl.sv | 98 +++++++++
 tb/tb_up_down_counter_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/up_down_counter_ctrl.sv
// Sequencer for a chain of BCD up/down digit counters: tick prescaler, carry/borrow
// enable ripple, shared direction and clear. UP_DOWN_CTRL_LIMIT_EN enables terminal-count stop.
module up_down_counter_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter bit UP_DEFAULT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clr,
    input  logic                    dir_toggle,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [NUM_DIGITS-1:0]   en_vec,
    output logic                    up_down,
    output logic                    counter_rst,
    output logic                    tick,
    output logic                    running,
    output logic                    done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
`ifdef UP_DOWN_CTRL_LIMIT_EN
    localparam logic [1:0] ST_DONE  = 2'd3;
`endif

    logic [1:0]            state;
    logic [PW-1:0]         pre;
    logic [NUM_DIGITS-1:0] term;
    logic [NUM_DIGITS:0]   chain;
    logic [NUM_DIGITS-1:0] en_raw;
    logic                  limit_hit;

    assign tick    = (state == ST_RUN) && (pre == PRE_MAX);
    assign running = (state == ST_RUN);

    // chain[i] is set when every digit below i sits at its terminal value
    assign chain[0] = 1'b1;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign term[i]    = up_down ? (digits_in[4*i +: 4] == 4'd9)
                                    : (digits_in[4*i +: 4] == 4'd0);
        assign chain[i+1] = chain[i] & term[i];
        assign en_raw[i]  = tick & chain[i];
    end

`ifdef UP_DOWN_CTRL_LIMIT_EN
    assign limit_hit = tick & chain[NUM_DIGITS];
    assign done      = (state == ST_DONE);
`else
    assign limit_hit = 1'b0;
    assign done      = 1'b0;
`endif

    assign en_vec = limit_hit ? '0 : en_raw;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pre         <= '0;
            up_down     <= UP_DEFAULT;
            counter_rst <= 1'b1;
        end else begin
            counter_rst <= clr;
            if (clr) begin
                state <= ST_IDLE;
                pre   <= '0;
            end else begin
                if (dir_toggle)
                    up_down <= ~up_down;
                case (state)
                    ST_IDLE: if (start) state <= ST_RUN;
                    ST_PAUSE: if (start) state <= ST_RUN;
                    ST_RUN: begin
                        // stop freezes pre even on a tick cycle; en_vec has already fired
                        if (stop)
                            state <= ST_PAUSE;
                        else if (limit_hit) begin
`ifdef UP_DOWN_CTRL_LIMIT_EN
                            state <= ST_DONE;
`endif
                            pre   <= '0;
                        end else
                            pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
                    end
`ifdef UP_DOWN_CTRL_LIMIT_EN
                    ST_DONE: if (dir_toggle) state <= ST_PAUSE;
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_up_down_counter_ctrl.sv
// Directed table-driven bench for up_down_counter_ctrl (NUM_DIGITS=2, TICK_DIV=3).
module tb_up_down_counter_ctrl;
    typedef struct {
        logic       start, stop, clr, tog;
        logic [7:0] dig;
        logic [1:0] en;
        logic       tick, run, done, crst, ud;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, clr, dir_toggle;
    logic [7:0] digits_in;
    logic [1:0] en_vec;
    logic       up_down, counter_rst, tick, running, done;
    int         checks = 0;
    int         failures = 0;
    vec_t       vq[$];

    up_down_counter_ctrl #(.NUM_DIGITS(2), .TICK_DIV(3), .UP_DEFAULT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .dir_toggle(dir_toggle), .digits_in(digits_in), .en_vec(en_vec),
        .up_down(up_down), .counter_rst(counter_rst), .tick(tick),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, sp, cl, tg, input logic [7:0] dg,
                                input logic [1:0] en, input logic tk, rn, dn, cr, ud);
        vec_t v;
        v.start = st; v.stop = sp; v.clr = cl; v.tog = tg; v.dig = dg;
        v.en = en; v.tick = tk; v.run = rn; v.done = dn; v.crst = cr; v.ud = ud;
        return v;
    endfunction

    initial begin
        //               st sp cl tg dig    en    tk rn dn cr ud
        vq.push_back(mk(0, 0, 0, 0, 8'h09, 2'b00, 0, 0, 0, 1, 1)); // r0 out of reset
        vq.push_back(mk(1, 0, 0, 0, 8'h09, 2'b00, 0, 0, 0, 0, 1)); // r1 start
        vq.push_back(mk(0, 0, 0, 0, 8'h09, 2'b00, 0, 1, 0, 0, 1)); // pre0
        vq.push_back(mk(0, 0, 0, 0, 8'h09, 2'b00, 0, 1, 0, 0, 1)); // pre1
        vq.push_back(mk(0, 0, 0, 0, 8'h09, 2'b11, 1, 1, 0, 0, 1)); // r4 tick, carry
        vq.push_back(mk(0, 0, 0, 0, 8'h10, 2'b00, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 8'h10, 2'b00, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 8'h10, 2'b01, 1, 1, 0, 0, 1)); // r7 tick no carry
        vq.push_back(mk(0, 0, 0, 0, 8'h11, 2'b00, 0, 1, 0, 0, 1)); // pre0
        vq.push_back(mk(0, 1, 0, 0, 8'h11, 2'b00, 0, 1, 0, 0, 1)); // r9 stop at pre1
        vq.push_back(mk(0, 0, 0, 0, 8'h11, 2'b00, 0, 0, 0, 0, 1)); // paused
        vq.push_back(mk(1, 0, 0, 0, 8'h11, 2'b00, 0, 0, 0, 0, 1)); // resume
        vq.push_back(mk(1, 0, 0, 0, 8'h11, 2'b00, 0, 1, 0, 0, 1)); // pre1 held
        vq.push_back(mk(0, 0, 0, 0, 8'h11, 2'b01, 1, 1, 0, 0, 1)); // r13 tick
        vq.push_back(mk(0, 0, 0, 0, 8'h09, 2'b00, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 8'h09, 2'b00, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 1, 8'h09, 2'b11, 1, 1, 0, 0, 1)); // r16 toggle+tick, old dir
        vq.push_back(mk(0, 0, 0, 0, 8'h10, 2'b00, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 8'h10, 2'b00, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 8'h10, 2'b11, 1, 1, 0, 0, 0)); // r19 borrow
        vq.push_back(mk(0, 0, 0, 0, 8'h00, 2'b00, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 8'h00, 2'b00, 0, 1, 0, 0, 0));
`ifdef UP_DOWN_CTRL_LIMIT_EN
        vq.push_back(mk(0, 0, 0, 0, 8'h00, 2'b00, 1, 1, 0, 0, 0)); // r22 limit hit
        vq.push_back(mk(1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 1, 0, 0)); // DONE, start ignored
        vq.push_back(mk(0, 0, 0, 1, 8'h00, 2'b00, 0, 0, 1, 0, 0)); // toggle -> PAUSE
        vq.push_back(mk(0, 0, 0, 0, 8'h99, 2'b00, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 1, 1, 1, 8'h99, 2'b00, 0, 0, 0, 0, 1)); // r26 clr+stop+start
`else
        vq.push_back(mk(0, 0, 0, 0, 8'h00, 2'b11, 1, 1, 0, 0, 0)); // r22 wrap 00 -> 99
        vq.push_back(mk(1, 0, 0, 0, 8'h99, 2'b00, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 8'h99, 2'b00, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 8'h99, 2'b11, 1, 1, 0, 0, 1)); // up at 99: wrap
        vq.push_back(mk(1, 1, 1, 1, 8'h99, 2'b00, 0, 1, 0, 0, 1)); // r26 clr+stop+start
`endif
        vq.push_back(mk(0, 0, 0, 0, 8'h35, 2'b00, 0, 0, 0, 1, 1)); // clear pulse, tog ignored
        vq.push_back(mk(1, 0, 0, 0, 8'h35, 2'b00, 0, 0, 0, 0, 1)); // one cycle only
        vq.push_back(mk(0, 0, 0, 0, 8'h35, 2'b00, 0, 1, 0, 0, 1)); // pre restarted at 0
        vq.push_back(mk(0, 0, 0, 0, 8'h35, 2'b00, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 8'h35, 2'b01, 1, 1, 0, 0, 1)); // r31 stop+tick
        vq.push_back(mk(0, 0, 0, 0, 8'h35, 2'b00, 0, 0, 0, 0, 1)); // paused
        vq.push_back(mk(0, 0, 1, 0, 8'h35, 2'b00, 0, 0, 0, 0, 1)); // clr held 2 cycles
        vq.push_back(mk(0, 0, 1, 0, 8'h35, 2'b00, 0, 0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 8'h35, 2'b00, 0, 0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 8'h35, 2'b00, 0, 0, 0, 0, 1));

        rst = 1'b0; start = 0; stop = 0; clr = 0; dir_toggle = 0; digits_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_crst", {7'd0, counter_rst}, 8'd1);
        chk("rst_en",   {6'd0, en_vec}, 8'd0);
        chk("rst_ud",   {7'd0, up_down}, 8'd1);
        chk("rst_run",  {7'd0, running}, 8'd0);
        chk("rst_tick", {7'd0, tick}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = 1'b1; start = vq[i].start; stop = vq[i].stop; clr = vq[i].clr;
            dir_toggle = vq[i].tog; digits_in = vq[i].dig;
            #1;
            chk($sformatf("r%0d_en", i),   {6'd0, en_vec},      {6'd0, vq[i].en});
            chk($sformatf("r%0d_tick", i), {7'd0, tick},        {7'd0, vq[i].tick});
            chk($sformatf("r%0d_run", i),  {7'd0, running},     {7'd0, vq[i].run});
            chk($sformatf("r%0d_done", i), {7'd0, done},        {7'd0, vq[i].done});
            chk($sformatf("r%0d_crst", i), {7'd0, counter_rst}, {7'd0, vq[i].crst});
            chk($sformatf("r%0d_ud", i),   {7'd0, up_down},     {7'd0, vq[i].ud});
        end

        // reset in the middle of RUN with direction flipped
        @(negedge clk); start = 1; stop = 0; clr = 0; dir_toggle = 0;
        @(negedge clk); start = 0; dir_toggle = 1;
        @(negedge clk); dir_toggle = 0; #1;
        chk("mid_run", {7'd0, running}, 8'd1);
        chk("mid_ud",  {7'd0, up_down}, 8'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mrst_run",  {7'd0, running}, 8'd0);
        chk("mrst_crst", {7'd0, counter_rst}, 8'd1);
        chk("mrst_ud",   {7'd0, up_down}, 8'd1);
        chk("mrst_tick", {7'd0, tick}, 8'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
